// File: rtl/evu_event_packer_if.sv
// Event-in / packet-out bundle for evu_event_packer.
// EVU_PACK_TIMESTAMP_EN widens the packet by TS_W timestamp bits at the MSB.
interface evu_event_packer_if #(
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned INFO_W    = 3,
  parameter int unsigned TS_W      = 32
);
`ifdef EVU_PACK_TIMESTAMP_EN
  localparam int unsigned TS_EN = 1;
`else
  localparam int unsigned TS_EN = 0;
`endif
  localparam int unsigned PKT_W = 2 + INFO_W + NUM_LINES * CNT_W + TS_EN * TS_W;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic                 enable_i;
  logic [NUM_LINES-1:0] e_id_i;
  logic [INFO_W-1:0]    e_info_i;
  logic                 s_id_i;
  logic                 pkt_valid_o;
  logic                 pkt_ready_i;
  logic [PKT_W-1:0]     pkt_data_o;
  logic [LVL_W-1:0]     fifo_level_o;
  logic [15:0]          drop_cnt_o;

  modport slave (
    input  enable_i, e_id_i, e_info_i, s_id_i, pkt_ready_i,
    output pkt_valid_o, pkt_data_o, fifo_level_o, drop_cnt_o
  );

  modport master (
    output enable_i, e_id_i, e_info_i, s_id_i, pkt_ready_i,
    input  pkt_valid_o, pkt_data_o, fifo_level_o, drop_cnt_o
  );
endinterface

// File: rtl/evu_event_packer.sv
// Windowed per-line event counter that packs counts + context into packets held in a FWFT FIFO.
// EVU_PACK_TIMESTAMP_EN adds a free-running timestamp captured in the window close cycle.
module evu_event_packer #(
  parameter int unsigned NUM_LINES     = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned INFO_W        = 3,
  parameter int unsigned TS_W          = 32
) (
  input logic               clk_i,
  input logic               rst_ni,
  evu_event_packer_if.slave bus
);
`ifdef EVU_PACK_TIMESTAMP_EN
  localparam int unsigned TS_EN = 1;
`else
  localparam int unsigned TS_EN = 0;
`endif
  localparam int unsigned PKT_W = 2 + INFO_W + NUM_LINES * CNT_W + TS_EN * TS_W;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned WC_W  = $clog2(WINDOW_CYCLES);

  typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} state_t;
  typedef logic [NUM_LINES-1:0][CNT_W-1:0] cnt_vec_t;

  state_t            state_q, state_d;
  cnt_vec_t          cnt_q, cnt_d, cnt_inc_c, cnt_load_c, pkt_cnt_c;
  logic [INFO_W-1:0] info_q, info_d;
  logic              sticky_q, sticky_d, pkt_sticky_c;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic              push_c, early_c;
  logic [PKT_W-1:0]  pkt_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic b);
    if (b && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end
    return v;
  endfunction

  // Saturated running counts and the fresh-window load value for the current strobes
  always_comb begin
    cnt_inc_c  = '0;
    cnt_load_c = '0;
    for (int i = 0; i < int'(NUM_LINES); i++) begin
      cnt_inc_c[i]  = sat_inc(cnt_q[i], bus.e_id_i[i]);
      cnt_load_c[i] = CNT_W'(bus.e_id_i[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      info_q   <= '0;
      sticky_q <= 1'b0;
      wc_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      info_q   <= info_d;
      sticky_q <= sticky_d;
      wc_q     <= wc_d;
    end
  end

  // Window control: a context change takes priority over the regular window end
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    info_d       = info_q;
    sticky_d     = sticky_q;
    wc_d         = wc_q;
    push_c       = 1'b0;
    early_c      = 1'b0;
    pkt_cnt_c    = cnt_q;
    pkt_sticky_c = sticky_q;
    case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          state_d  = OPEN;
          info_d   = bus.e_info_i;
          cnt_d    = cnt_load_c;
          sticky_d = bus.s_id_i;
          wc_d     = WC_W'(1);
        end
      end
      OPEN: begin
        if (!bus.enable_i) begin
          state_d  = IDLE;
          cnt_d    = '0;
          sticky_d = 1'b0;
          wc_d     = '0;
        end else if (bus.e_info_i != info_q) begin
          push_c   = 1'b1;
          early_c  = 1'b1;
          info_d   = bus.e_info_i;
          cnt_d    = cnt_load_c;
          sticky_d = bus.s_id_i;
          wc_d     = WC_W'(1);
        end else if (wc_q == WC_W'(WINDOW_CYCLES - 1)) begin
          push_c       = 1'b1;
          pkt_cnt_c    = cnt_inc_c;
          pkt_sticky_c = sticky_q | bus.s_id_i;
          cnt_d        = '0;
          sticky_d     = 1'b0;
          wc_d         = '0;
        end else begin
          cnt_d    = cnt_inc_c;
          sticky_d = sticky_q | bus.s_id_i;
          wc_d     = wc_q + WC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef EVU_PACK_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  assign pkt_c = {ts_q, early_c, pkt_sticky_c, info_q, pkt_cnt_c};
`else
  assign pkt_c = {early_c, pkt_sticky_c, info_q, pkt_cnt_c};
`endif

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [15:0]      drop_cnt_q;
  logic             full_c, pop_c, push_ok_c, drop_c;

  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign full_c    = (level_q == LW'(DEPTH));
  assign pop_c     = (level_q != '0) & bus.pkt_ready_i;
  assign push_ok_c = push_c & (~full_c | pop_c);
  assign drop_c    = push_c & full_c & ~pop_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push_ok_c) begin
        mem_q[wr_ptr_q] <= pkt_c;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_q + LW'(push_ok_c) - LW'(pop_c);
      if (drop_c && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign bus.pkt_valid_o  = (level_q != '0);
  assign bus.pkt_data_o   = mem_q[rd_ptr_q];
  assign bus.fifo_level_o = level_q;
  assign bus.drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_evu_event_packer.sv
// Bench for evu_event_packer: a window/queue model checked every cycle plus directed literal checks.
// Two instances share stimulus: CNT_W=4 and CNT_W=3 (saturation); EVU_PACK_TIMESTAMP_EN adds ts checks.
module tb_evu_event_packer;
  localparam int NL  = 4;
  localparam int WIN = 8;
  localparam int DEP = 2;
  localparam int IW  = 3;
  localparam int TSW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_on = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  evu_event_packer_if #(.NUM_LINES(NL), .CNT_W(4), .DEPTH(DEP), .INFO_W(IW), .TS_W(TSW)) bi4 ();
  evu_event_packer_if #(.NUM_LINES(NL), .CNT_W(3), .DEPTH(DEP), .INFO_W(IW), .TS_W(TSW)) bi3 ();

  evu_event_packer #(.NUM_LINES(NL), .CNT_W(4), .WINDOW_CYCLES(WIN), .DEPTH(DEP),
                     .INFO_W(IW), .TS_W(TSW)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bi4));
  evu_event_packer #(.NUM_LINES(NL), .CNT_W(3), .WINDOW_CYCLES(WIN), .DEPTH(DEP),
                     .INFO_W(IW), .TS_W(TSW)) dut_sat (.clk_i(clk), .rst_ni(rst_n), .bus(bi3));

  assign bi3.enable_i    = bi4.enable_i;
  assign bi3.e_id_i      = bi4.e_id_i;
  assign bi3.e_info_i    = bi4.e_info_i;
  assign bi3.s_id_i      = bi4.s_id_i;
  assign bi3.pkt_ready_i = bi4.pkt_ready_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a window is the list of strobe samples seen since it opened
  typedef struct {
    logic [31:0] sums;
    int          info;
    bit          s;
    bit          early;
    int          ts;
  } pkt_t;

  pkt_t        fq[$];
  logic [3:0]  win_e[$];
  bit          win_s[$];
  bit          m_open = 1'b0;
  int          m_info = 0;
  int          m_ts   = 0;
  int          m_drop = 0;

  function automatic pkt_t close_win(input bit early, input int ts);
    pkt_t p;
    int   tot[4];
    for (int i = 0; i < 4; i++) tot[i] = 0;
    p.s = 1'b0;
    foreach (win_e[k]) begin
      for (int i = 0; i < 4; i++) tot[i] += int'(win_e[k][i]);
      p.s |= win_s[k];
    end
    p.sums  = {8'(tot[3]), 8'(tot[2]), 8'(tot[1]), 8'(tot[0])};
    p.info  = m_info;
    p.early = early;
    p.ts    = ts;
    return p;
  endfunction

  function automatic logic [63:0] exp_pkt(input pkt_t p, input int w);
    logic [63:0] v;
    int          c;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      c = int'(p.sums[8*i +: 8]);
      if (c > (1 << w) - 1) c = (1 << w) - 1;
      v |= 64'(c) << (i * w);
    end
    v |= 64'(p.info) << (4 * w);
    v |= 64'(p.s) << (4 * w + 3);
    v |= 64'(p.early) << (4 * w + 4);
`ifdef EVU_PACK_TIMESTAMP_EN
    v |= 64'(p.ts % 16) << (4 * w + 5);
`endif
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit         pop;
    bit         push;
    pkt_t       p;
    bit         en;
    logic [3:0] e;
    int         inf;
    bit         s;
    if (!rst_n) begin
      fq.delete();
      win_e.delete();
      win_s.delete();
      m_open = 1'b0;
      m_info = 0;
      m_ts   = 0;
      m_drop = 0;
    end else begin
      en   = bi4.enable_i;
      e    = bi4.e_id_i;
      inf  = int'(bi4.e_info_i);
      s    = bi4.s_id_i;
      pop  = (fq.size() > 0) && bi4.pkt_ready_i;
      push = 1'b0;
      if (!m_open) begin
        if (en) begin
          m_open = 1'b1;
          m_info = inf;
          win_e  = {e};
          win_s  = {s};
        end
      end else if (!en) begin
        m_open = 1'b0;
        win_e.delete();
        win_s.delete();
      end else if (inf != m_info) begin
        push   = 1'b1;
        p      = close_win(1'b1, m_ts);
        m_info = inf;
        win_e  = {e};
        win_s  = {s};
      end else begin
        win_e.push_back(e);
        win_s.push_back(s);
        if (win_e.size() == WIN) begin
          push = 1'b1;
          p    = close_win(1'b0, m_ts);
          win_e.delete();
          win_s.delete();
        end
      end
      if (pop) void'(fq.pop_front());
      if (push) begin
        if (fq.size() < DEP) fq.push_back(p);
        else if (m_drop < 65535) m_drop++;
      end
      m_ts++;
    end
  end

  always @(negedge clk) begin : cmp
    int lvl;
    if (chk_on) begin
      lvl = fq.size();
      check("m_valid",     64'(bi4.pkt_valid_o),  64'(lvl > 0));
      check("m_valid_sat", 64'(bi3.pkt_valid_o),  64'(lvl > 0));
      check("m_level",     64'(bi4.fifo_level_o), 64'(lvl));
      check("m_level_sat", 64'(bi3.fifo_level_o), 64'(lvl));
      check("m_drop",      64'(bi4.drop_cnt_o),   64'(m_drop));
      check("m_drop_sat",  64'(bi3.drop_cnt_o),   64'(m_drop));
      if (lvl > 0) begin
        check("m_data",     64'(bi4.pkt_data_o), exp_pkt(fq[0], 4));
        check("m_data_sat", 64'(bi3.pkt_data_o), exp_pkt(fq[0], 3));
      end
    end
  end

  task automatic step(input bit en, input logic [3:0] eid, input logic [2:0] inf,
                      input bit s, input bit rdy);
    bi4.enable_i    = en;
    bi4.e_id_i      = eid;
    bi4.e_info_i    = inf;
    bi4.s_id_i      = s;
    bi4.pkt_ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bi4.enable_i    = 1'b0;
    bi4.e_id_i      = '0;
    bi4.e_info_i    = '0;
    bi4.s_id_i      = 1'b0;
    bi4.pkt_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;
    check("rst_valid", 64'(bi4.pkt_valid_o),  64'd0);
    check("rst_level", 64'(bi4.fifo_level_o), 64'd0);
    check("rst_drop",  64'(bi4.drop_cnt_o),   64'd0);
    check("rst_data",  64'(bi4.pkt_data_o),   64'd0);
    rst_n = 1'b1;

    // Plain window close; s_id pulse mid-window sets the sticky bit
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 4'b0001, 3'd3, k == 3, 1'b1);
      if (k == 6) check("t1_not_yet", 64'(bi4.pkt_valid_o), 64'd0);
    end
    check("t1_valid", 64'(bi4.pkt_valid_o),        64'd1);
    check("t1_cnt0",  64'(bi4.pkt_data_o[3:0]),    64'd8);
    check("t1_cnt13", 64'(bi4.pkt_data_o[15:4]),   64'd0);
    check("t1_info",  64'(bi4.pkt_data_o[18:16]),  64'd3);
    check("t1_s",     64'(bi4.pkt_data_o[19]),     64'd1);
    check("t1_early", 64'(bi4.pkt_data_o[20]),     64'd0);
    check("t1_sat0",  64'(bi3.pkt_data_o[2:0]),    64'd7);
`ifdef EVU_PACK_TIMESTAMP_EN
    check("t1_ts",    64'(bi4.pkt_data_o[24:21]),  64'd7);
`endif

    // All lines every cycle: 3-bit counts saturate at 7
    for (int k = 0; k < 8; k++) step(1'b1, 4'b1111, 3'd3, k == 7, 1'b1);
    check("t2_sat",   64'(bi3.pkt_data_o[11:0]),   64'hFFF);
    check("t2_full",  64'(bi4.pkt_data_o[15:0]),   64'h8888);
    check("t2_s",     64'(bi4.pkt_data_o[19]),     64'd1);
`ifdef EVU_PACK_TIMESTAMP_EN
    check("t2_ts",    64'(bi4.pkt_data_o[24:21]),  64'd15);
`endif
    for (int k = 0; k < 8; k++) step(1'b1, 4'b0001, 3'd3, 1'b0, 1'b1);
    check("t2_fresh_sat", 64'(bi3.pkt_data_o[11:0]), 64'h007);
    check("t2_fresh",     64'(bi4.pkt_data_o[15:0]), 64'h0008);
`ifdef EVU_PACK_TIMESTAMP_EN
    check("t2_ts_wrap",   64'(bi4.pkt_data_o[24:21]), 64'd7);
`endif

    // Context change at window cycle 3; the change cycle opens the next window
    for (int k = 0; k < 3; k++) step(1'b1, 4'b0010, 3'd3, 1'b0, 1'b1);
    step(1'b1, 4'b0010, 3'd5, 1'b1, 1'b1);
    check("t3_cnt",   64'(bi4.pkt_data_o[15:0]),   64'h0030);
    check("t3_info",  64'(bi4.pkt_data_o[18:16]),  64'd3);
    check("t3_early", 64'(bi4.pkt_data_o[20]),     64'd1);
    check("t3_s",     64'(bi4.pkt_data_o[19]),     64'd0);
    for (int k = 0; k < 7; k++) step(1'b1, 4'b0010, 3'd5, 1'b0, 1'b1);
    check("t3b_cnt",  64'(bi4.pkt_data_o[15:0]),   64'h0080);
    check("t3b_info", 64'(bi4.pkt_data_o[18:16]),  64'd5);
    check("t3b_early",64'(bi4.pkt_data_o[20]),     64'd0);
    check("t3b_s",    64'(bi4.pkt_data_o[19]),     64'd1);
    check("t3b_sat",  64'(bi3.pkt_data_o[11:0]),   64'h038);

    // Stalled consumer: two windows held, third dropped, then push+pop while full
    step(1'b0, 4'b0000, 3'd5, 1'b0, 1'b1);
    check("t4_empty", 64'(bi4.fifo_level_o), 64'd0);
    for (int k = 0; k < 8; k++) step(1'b1, 4'b0001, 3'd5, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b1, 4'b0010, 3'd5, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b1, 4'b0100, 3'd5, 1'b0, 1'b0);
    check("t4_level", 64'(bi4.fifo_level_o),      64'd2);
    check("t4_drop",  64'(bi4.drop_cnt_o),        64'd1);
    check("t4_head",  64'(bi4.pkt_data_o[15:0]),  64'h0008);
    for (int k = 0; k < 8; k++) step(1'b1, 4'b1000, 3'd5, 1'b0, k == 7);
    check("t4_level_pp", 64'(bi4.fifo_level_o),     64'd2);
    check("t4_drop_pp",  64'(bi4.drop_cnt_o),       64'd1);
    check("t4_head_pp",  64'(bi4.pkt_data_o[15:0]), 64'h0080);
    step(1'b0, 4'b0000, 3'd5, 1'b0, 1'b1);
    step(1'b0, 4'b0000, 3'd5, 1'b0, 1'b1);
    check("t4_drained", 64'(bi4.fifo_level_o), 64'd0);

    // Enable drop discards the window; re-enable counts only new events
    for (int k = 0; k < 5; k++) step(1'b1, 4'b1000, 3'd2, 1'b0, 1'b1);
    step(1'b0, 4'b1000, 3'd2, 1'b0, 1'b1);
    check("t5_nopkt", 64'(bi4.pkt_valid_o), 64'd0);
    for (int k = 0; k < 7; k++) step(1'b1, 4'b0001, 3'd2, 1'b0, 1'b1);
    check("t5_not_yet", 64'(bi4.pkt_valid_o), 64'd0);
    step(1'b1, 4'b0001, 3'd2, 1'b0, 1'b1);
    check("t5_valid", 64'(bi4.pkt_valid_o),        64'd1);
    check("t5_cnt",   64'(bi4.pkt_data_o[15:0]),   64'h0008);
    check("t5_info",  64'(bi4.pkt_data_o[18:16]),  64'd2);

    // Asynchronous reset mid-window with one entry held
    for (int k = 0; k < 3; k++) step(1'b1, 4'b0001, 3'd2, 1'b0, 1'b0);
    check("t5_held", 64'(bi4.fifo_level_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(bi4.pkt_valid_o),  64'd0);
    check("t5_rst_level", 64'(bi4.fifo_level_o), 64'd0);
    check("t5_rst_drop",  64'(bi4.drop_cnt_o),   64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 4'b0000, 3'd0, 1'b0, 1'b1);
    step(1'b0, 4'b0000, 3'd0, 1'b0, 1'b1);
    check("t5_after_rst", 64'(bi4.pkt_valid_o), 64'd0);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
